// File: rtl/dm_responder.sv
// Multi-cycle data-memory responder: accepts one load/store at a time and
// answers with a single-cycle response LATENCY cycles after the accept.
module dm_responder #(
    parameter int DEPTH   = 3072,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_op,
    input  logic        req_ext,
    input  logic [31:0] req_pc,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    // state | meaning
    // IDLE  | ready for a request
    // WAIT  | request latched, down-counting the remaining latency
    // RESP  | rsp_valid high for this single cycle

    localparam int          AW        = $clog2(DEPTH);
    localparam logic [31:0] LIMIT     = 32'(4 * DEPTH);
    localparam logic [3:0]  WAIT_INIT = 4'((LATENCY > 1) ? LATENCY - 2 : 0);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        l_we, l_ext;
    logic [31:0] l_addr, l_wdata, l_pc;
    logic [1:0]  l_op;

    logic        accept, to_resp, commit, err;
    logic        cur_we, cur_ext;
    logic [31:0] cur_addr, cur_wdata, cur_pc;
    logic [1:0]  cur_op;
    logic [AW-1:0] idx;
    logic [31:0] rd_word, load_data, merged;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] mem [DEPTH];

    assign accept  = req_valid && req_ready;
    assign to_resp = (accept && LATENCY == 1) || (state == WAIT && cnt == 4'd0);

    // With LATENCY=1 the memory access happens on the accept edge itself,
    // before the latches are loaded, so IDLE looks at the live request.
    always_comb begin
        if (state == IDLE) begin
            cur_we = req_we; cur_addr = req_addr; cur_wdata = req_wdata;
            cur_op = req_op; cur_ext = req_ext;   cur_pc = req_pc;
        end else begin
            cur_we = l_we;   cur_addr = l_addr;   cur_wdata = l_wdata;
            cur_op = l_op;   cur_ext = l_ext;     cur_pc = l_pc;
        end
    end

    assign err = (cur_op == 2'b11)
              || (cur_op == 2'b01 && cur_addr[0])
              || (cur_op == 2'b00 && cur_addr[1:0] != 2'b00)
              || (cur_addr >= LIMIT);

    assign idx     = cur_addr[AW+1:2];
    assign rd_word = err ? '0 : mem[idx];
    assign rd_half = cur_addr[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        case (cur_addr[1:0])
            2'd0:    rd_byte = rd_word[7:0];
            2'd1:    rd_byte = rd_word[15:8];
            2'd2:    rd_byte = rd_word[23:16];
            default: rd_byte = rd_word[31:24];
        endcase
    end

    always_comb begin
        case (cur_op)
            2'b00:   load_data = rd_word;
            2'b01:   load_data = {{16{cur_ext & rd_half[15]}}, rd_half};
            2'b10:   load_data = {{24{cur_ext & rd_byte[7]}}, rd_byte};
            default: load_data = '0;
        endcase
    end

    always_comb begin
        merged = rd_word;
        case (cur_op)
            2'b00: merged = cur_wdata;
            2'b01: begin
                if (cur_addr[1]) merged[31:16] = cur_wdata[15:0];
                else             merged[15:0]  = cur_wdata[15:0];
            end
            2'b10: begin
                case (cur_addr[1:0])
                    2'd0:    merged[7:0]   = cur_wdata[7:0];
                    2'd1:    merged[15:8]  = cur_wdata[7:0];
                    2'd2:    merged[23:16] = cur_wdata[7:0];
                    default: merged[31:24] = cur_wdata[7:0];
                endcase
            end
            default: merged = rd_word;
        endcase
    end

    assign commit = to_resp && cur_we && !err;

    for (genvar g = 0; g < DEPTH; g++) begin : g_word
        logic [31:0] word_q;
        always_ff @(posedge clk or negedge reset) begin
            if (!reset)
                word_q <= '0;
            else if (commit && idx == AW'(g))
                word_q <= merged;
        end
        assign mem[g] = word_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            l_we      <= 1'b0;
            l_addr    <= '0;
            l_wdata   <= '0;
            l_op      <= '0;
            l_ext     <= 1'b0;
            l_pc      <= '0;
        end else begin
            rsp_valid <= to_resp;
            if (to_resp) begin
                rsp_rdata <= (cur_we || err) ? '0 : load_data;
                rsp_err   <= err;
            end
            case (state)
                IDLE: if (accept) begin
                    l_we      <= req_we;
                    l_addr    <= req_addr;
                    l_wdata   <= req_wdata;
                    l_op      <= req_op;
                    l_ext     <= req_ext;
                    l_pc      <= req_pc;
                    req_ready <= 1'b0;
                    cnt       <= WAIT_INIT;
                    state     <= (LATENCY > 1) ? WAIT : RESP;
                end
                WAIT: begin
                    if (cnt == 4'd0) state <= RESP;
                    else             cnt   <= cnt - 4'd1;
                end
                RESP: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (reset && commit)
            $display("@%h: *%h <= %h", cur_pc, {cur_addr[31:2], 2'b00}, merged);
    end
`endif

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder: vector table on a LATENCY=2 instance plus
// handshake-throughput and reset-abort sequences across LATENCY 1/2/4.
module tb_dm_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        we = 1'b0, ext = 1'b0;
    logic [31:0] addr = '0, wdata = '0, pc = '0;
    logic [1:0]  op = '0;
    logic        valid1 = 1'b0, valid2 = 1'b0, valid4 = 1'b0;
    logic        ready1, ready2, ready4;
    logic        rv1, rv2, rv4;
    logic [31:0] rd1, rd2, rd4;
    logic        er1, er2, er4;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dm_responder #(.DEPTH(3072), .LATENCY(2)) u2 (
        .clk(clk), .reset(reset), .req_valid(valid2), .req_ready(ready2),
        .req_we(we), .req_addr(addr), .req_wdata(wdata), .req_op(op),
        .req_ext(ext), .req_pc(pc), .rsp_valid(rv2), .rsp_rdata(rd2), .rsp_err(er2));

    dm_responder #(.DEPTH(16), .LATENCY(1)) u1 (
        .clk(clk), .reset(reset), .req_valid(valid1), .req_ready(ready1),
        .req_we(we), .req_addr(addr), .req_wdata(wdata), .req_op(op),
        .req_ext(ext), .req_pc(pc), .rsp_valid(rv1), .rsp_rdata(rd1), .rsp_err(er1));

    dm_responder #(.DEPTH(16), .LATENCY(4)) u4 (
        .clk(clk), .reset(reset), .req_valid(valid4), .req_ready(ready4),
        .req_we(we), .req_addr(addr), .req_wdata(wdata), .req_op(op),
        .req_ext(ext), .req_pc(pc), .rsp_valid(rv4), .rsp_rdata(rd4), .rsp_err(er4));

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  op;
        logic        ext;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vt[26];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One request on the LATENCY=2 instance; inputs are scrambled after accept.
    task automatic do_req(input vec_t v, input string name);
        int n;
        @(negedge clk);
        chk({name, " ready_idle"}, 32'(ready2), 32'd1);
        we = v.we; addr = v.addr; wdata = v.wdata; op = v.op; ext = v.ext;
        pc = pc + 32'd4;
        valid2 = 1'b1;
        @(negedge clk);
        valid2 = 1'b0;
        we = ~we; addr = ~addr; wdata = ~wdata; op = op ^ 2'b01; ext = ~ext;
        chk({name, " ready_busy"}, 32'(ready2), 32'd0);
        n = 1;
        while (!rv2 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({name, " latency"}, 32'(n), 32'd2);
        chk({name, " rdata"}, rd2, v.exp_rdata);
        chk({name, " err"}, 32'(er2), 32'(v.exp_err));
        chk({name, " ready_in_rsp"}, 32'(ready2), 32'd0);
        @(negedge clk);
        chk({name, " valid_one_cycle"}, 32'(rv2), 32'd0);
        chk({name, " rdata_hold"}, rd2, v.exp_rdata);
        chk({name, " ready_after"}, 32'(ready2), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat[3];
        int acc[3], bad_gap[3], viol[3], last_acc[3], first_acc[3], first_rsp[3];
        logic [2:0] rdy_v, rsp_v;
        int rsp_seen;
        vec_t v;

        //        we    addr          wdata         op     ext   exp_rdata     err
        vt[0]  = '{1'b1, 32'h10,   32'h12345678, 2'b00, 1'b0, 32'h0,        1'b0};
        vt[1]  = '{1'b0, 32'h10,   32'h0,        2'b00, 1'b0, 32'h12345678, 1'b0};
        vt[2]  = '{1'b1, 32'h13,   32'hDEADBEAB, 2'b10, 1'b0, 32'h0,        1'b0};
        vt[3]  = '{1'b0, 32'h13,   32'h0,        2'b10, 1'b1, 32'hFFFFFFAB, 1'b0};
        vt[4]  = '{1'b0, 32'h13,   32'h0,        2'b10, 1'b0, 32'h000000AB, 1'b0};
        vt[5]  = '{1'b0, 32'h10,   32'h0,        2'b00, 1'b0, 32'hAB345678, 1'b0};
        vt[6]  = '{1'b1, 32'h22,   32'h77778001, 2'b01, 1'b0, 32'h0,        1'b0};
        vt[7]  = '{1'b0, 32'h22,   32'h0,        2'b01, 1'b1, 32'hFFFF8001, 1'b0};
        vt[8]  = '{1'b0, 32'h22,   32'h0,        2'b01, 1'b0, 32'h00008001, 1'b0};
        vt[9]  = '{1'b0, 32'h20,   32'h0,        2'b00, 1'b0, 32'h80010000, 1'b0};
        vt[10] = '{1'b0, 32'h11,   32'h0,        2'b00, 1'b0, 32'h0,        1'b1};
        vt[11] = '{1'b1, 32'h23,   32'h0000FFFF, 2'b01, 1'b0, 32'h0,        1'b1};
        vt[12] = '{1'b0, 32'h3000, 32'h0,        2'b00, 1'b0, 32'h0,        1'b1};
        vt[13] = '{1'b0, 32'h10,   32'h0,        2'b11, 1'b1, 32'h0,        1'b1};
        vt[14] = '{1'b1, 32'h10,   32'hFFFFFFFF, 2'b11, 1'b0, 32'h0,        1'b1};
        vt[15] = '{1'b0, 32'h10,   32'h0,        2'b00, 1'b0, 32'hAB345678, 1'b0};
        vt[16] = '{1'b0, 32'h11,   32'h0,        2'b10, 1'b1, 32'h00000056, 1'b0};
        vt[17] = '{1'b0, 32'h12,   32'h0,        2'b01, 1'b1, 32'hFFFFAB34, 1'b0};
        vt[18] = '{1'b0, 32'h10,   32'h0,        2'b01, 1'b1, 32'h00005678, 1'b0};
        vt[19] = '{1'b0, 32'h2FFC, 32'h0,        2'b00, 1'b0, 32'h0,        1'b0};
        vt[20] = '{1'b1, 32'h2FFC, 32'hCAFEF00D, 2'b00, 1'b0, 32'h0,        1'b0};
        vt[21] = '{1'b0, 32'h2FFF, 32'h0,        2'b10, 1'b1, 32'hFFFFFFCA, 1'b0};
        vt[22] = '{1'b1, 32'h3000, 32'h00000001, 2'b10, 1'b0, 32'h0,        1'b1};
        vt[23] = '{1'b0, 32'h0,    32'h0,        2'b00, 1'b0, 32'h0,        1'b0};
        vt[24] = '{1'b0, 32'h21,   32'h0,        2'b01, 1'b0, 32'h0,        1'b1};
        vt[25] = '{1'b0, 32'h12,   32'h0,        2'b00, 1'b0, 32'h0,        1'b1};

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst ready", 32'(ready2), 32'd1);
        chk("rst rsp_valid", 32'(rv2), 32'd0);
        chk("rst rdata", rd2, 32'h0);
        chk("rst err", 32'(er2), 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 26; i++) begin
            do_req(vt[i], $sformatf("vec%0d", i));
        end

        // Throughput with valid held high on all three latencies
        lat = '{1, 2, 4};
        for (int k = 0; k < 3; k++) begin
            acc[k] = 0; bad_gap[k] = 0; viol[k] = 0; last_acc[k] = -1;
            first_acc[k] = -1; first_rsp[k] = -1;
        end
        @(negedge clk);
        we = 1'b0; addr = 32'h0; op = 2'b00; ext = 1'b0;
        valid1 = 1'b1; valid2 = 1'b1; valid4 = 1'b1;
        for (int c = 0; c < 12; c++) begin
            rdy_v = {ready4, ready2, ready1};
            rsp_v = {rv4, rv2, rv1};
            for (int k = 0; k < 3; k++) begin
                if (rsp_v[k] && rdy_v[k]) viol[k]++;
                if (rsp_v[k] && first_rsp[k] < 0) first_rsp[k] = c;
                if (rdy_v[k]) begin
                    if (last_acc[k] >= 0 && c - last_acc[k] != lat[k] + 1) bad_gap[k]++;
                    if (first_acc[k] < 0) first_acc[k] = c;
                    last_acc[k] = c;
                    acc[k]++;
                end
            end
            @(negedge clk);
        end
        valid1 = 1'b0; valid2 = 1'b0; valid4 = 1'b0;
        repeat (6) @(negedge clk);
        chk("hold L1 accepts", 32'(acc[0]), 32'd6);
        chk("hold L2 accepts", 32'(acc[1]), 32'd4);
        chk("hold L4 accepts", 32'(acc[2]), 32'd3);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("hold L%0d gap", lat[k]), 32'(bad_gap[k]), 32'd0);
            chk($sformatf("hold L%0d ready_in_rsp", lat[k]), 32'(viol[k]), 32'd0);
            chk($sformatf("hold L%0d first_latency", lat[k]),
                32'(first_rsp[k] - first_acc[k]), 32'(lat[k]));
        end

        // Reset while a store is in flight
        @(negedge clk);
        we = 1'b1; addr = 32'h40; wdata = 32'h11111111; op = 2'b00; ext = 1'b0;
        valid2 = 1'b1;
        @(negedge clk);
        valid2 = 1'b0;
        chk("abort accepted", 32'(ready2), 32'd0);
        reset = 1'b0;
        #1;
        chk("abort ready", 32'(ready2), 32'd1);
        chk("abort rsp_valid", 32'(rv2), 32'd0);
        rsp_seen = 0;
        repeat (2) begin
            @(negedge clk);
            if (rv2) rsp_seen++;
        end
        reset = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (rv2) rsp_seen++;
        end
        chk("abort no_response", 32'(rsp_seen), 32'd0);
        v = '{1'b0, 32'h40, 32'h0, 2'b00, 1'b0, 32'h0, 1'b0};
        do_req(v, "abort lw40");
        v = '{1'b0, 32'h10, 32'h0, 2'b00, 1'b0, 32'h0, 1'b0};
        do_req(v, "abort lw10_cleared");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
